hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the IF/ID/EX/MEM/WB registers and consumes the decoded register indices (Rs1D/Rs2D from decode, Rs1E/Rs2E/RdE from execute, RdM/RdW from later stages). It produces the forwarding selects, the load-use stall, the branch/jump flush, and a data-memory wait-state sequencer. The sequencer freezes the whole pipe while memory is not ready and aborts with an error pulse after a bounded wait.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage hazard controller: forwarding, load-use stall, flush, memory wait sequencer
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        Rs1E,
  input  logic [4:0]        Rs2E,
  input  logic [4:0]        RdE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic [4:0]        RdM,
  input  logic              RegWriteM,
  input  logic [4:0]        RdW,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemReady,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemErr,
  output logic [PERF_W-1:0] StallCycles
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_wait_cnt;
  logic [CW-1:0]     w_wait_cnt_nxt;
  logic              r_mem_err;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              w_lw_stall;
  logic              w_mem_stall;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= (w_state_nxt == S_ERR);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (MemReqM && !MemReady) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemReady) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == CW'(MAX_WAIT)) begin
          w_state_nxt    = S_ERR;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CW'(1);
        end
      end
      S_ERR: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // The ERR cycle drops memStall so the stuck access is let go.
  assign w_mem_stall = MemReqM && !MemReady && (r_state == S_IDLE || r_state == S_WAIT);
  assign w_lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      w_fwd_a = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) w_fwd_a = 2'b01;
    w_fwd_b = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      w_fwd_b = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) w_fwd_b = 2'b01;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      StallF    = w_mem_stall || w_lw_stall;
      StallD    = w_mem_stall || w_lw_stall;
      StallE    = w_mem_stall;
      StallM    = w_mem_stall;
      FlushW    = w_mem_stall;
      FlushD    = PCSrcE && !w_mem_stall;
      FlushE    = (w_lw_stall || PCSrcE) && !w_mem_stall;
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (StallF && (r_stall_cycles != {PERF_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign MemErr      = r_mem_err;
  assign StallCycles = r_stall_cycles;

endmodule
